pixel_scan_ctrl: RTL and testbench

//  Raster sequencer directly upstream of fullModule. Scans an H_RES x V_RES frame, issuing one
//  (screen_x, screen_y) Q11.21 coordinate per valid pulse. Limits pixels in flight with a credit

---
 rtl/pixel_scan_ctrl_pkg.sv | 33 +++
 rtl/pixel_scan_ctrl_raster.sv | 40 ++++
 rtl/pixel_scan_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_pixel_scan_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_scan_ctrl_pkg.sv
// rtl/pixel_scan_ctrl_pkg.sv - shared widths, fixed-point types and defaults for the pixel scan controller
package pixel_scan_ctrl_pkg;

  // Q11.21 fixed point carried on every coordinate and vector lane
  localparam int FP_W        = 32;
  localparam int VEC3_W      = 3 * FP_W;
  localparam int SCREEN_FRAC = 21;

  // Default frame geometry
  localparam int DEF_H_RES = 640;
  localparam int DEF_V_RES = 480;

  // Raster counters cover up to 1024 columns/lines; credit counter covers up to 15 pixels
  localparam int CNT_W    = 10;
  localparam int CREDIT_W = 4;

  typedef logic signed [FP_W-1:0] fp;

  typedef struct packed {
    fp x;
    fp y;
    fp z;
  } vec3;

  function automatic vec3 make_vec3(input fp x, input fp y, input fp z);
    vec3 v;
    v.x = x;
    v.y = y;
    v.z = z;
    return v;
  endfunction

endpackage

// File: rtl/pixel_scan_ctrl_raster.sv
// rtl/pixel_scan_ctrl_raster.sv - raster-order x/y pixel counter for the scan controller
module pixel_raster_counter
  import pixel_scan_ctrl_pkg::*;
#(
  parameter int H_RES = DEF_H_RES,
  parameter int V_RES = DEF_V_RES
) (
  input  logic             clk,
  input  logic             rst_gen,
  input  logic             clear,
  input  logic             advance,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             last_pixel
);

  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(H_RES - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(V_RES - 1);

  logic line_end;

  assign line_end   = (x == X_LAST);
  assign last_pixel = line_end && (y == Y_LAST);

  // Step through the frame in raster order; the final pixel holds until the next clear
  always_ff @(posedge clk) begin
    if (rst_gen || clear) begin
      x <= '0;
      y <= '0;
    end else if (advance && !last_pixel) begin
      if (line_end) begin
        x <= '0;
        y <= y + CNT_W'(1);
      end else begin
        x <= x + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pixel_scan_ctrl.sv
// rtl/pixel_scan_ctrl.sv - raster sequencer issuing credit-limited pixel coordinates with frame-stable parameters
module pixel_scan_ctrl
  import pixel_scan_ctrl_pkg::*;
#(
  parameter int H_RES        = DEF_H_RES,
  parameter int V_RES        = DEF_V_RES,
  parameter int MAX_INFLIGHT = 1,
  parameter int FRAC         = SCREEN_FRAC
) (
  input  logic              clk,
  input  logic              rst_gen,
  input  logic              start,
  input  logic              continuous,
  input  logic              param_update,
  input  logic [VEC3_W-1:0] camera_forward_in,
  input  logic [VEC3_W-1:0] camera_right_in,
  input  logic [VEC3_W-1:0] ray_origin_in,
  input  logic [VEC3_W-1:0] light_pos_in,
  input  logic              sdf_sel_in,
  input  logic              result_valid,
  output logic              pix_valid,
  output logic [FP_W-1:0]   screen_x,
  output logic [FP_W-1:0]   screen_y,
  output logic [VEC3_W-1:0] camera_forward,
  output logic [VEC3_W-1:0] camera_right,
  output logic [VEC3_W-1:0] ray_origin,
  output logic [VEC3_W-1:0] light_pos,
  output logic              sdf_sel,
  output logic              busy,
  output logic              frame_done,
  output logic [15:0]       frame_count,
  output logic              err_underflow
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ISSUE,
    DRAIN,
    DONE
  } scan_state_t;

  scan_state_t state;
  scan_state_t state_next;

  logic [CREDIT_W-1:0] outstanding;
  logic [CREDIT_W-1:0] outstanding_next;
  logic                ret_ok;
  logic                ret_drop;
  logic                credit_free;
  logic                issue;
  logic                raster_clear;

  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             last_pixel;

  logic [VEC3_W-1:0] pend_camera_forward;
  logic [VEC3_W-1:0] pend_camera_right;
  logic [VEC3_W-1:0] pend_ray_origin;
  logic [VEC3_W-1:0] pend_light_pos;
  logic              pend_sdf_sel;

  pixel_raster_counter #(
    .H_RES (H_RES),
    .V_RES (V_RES)
  ) u_raster (
    .clk        (clk),
    .rst_gen    (rst_gen),
    .clear      (raster_clear),
    .advance    (issue),
    .x          (x),
    .y          (y),
    .last_pixel (last_pixel)
  );

  // A return with nothing outstanding is dropped and only flags the error
  assign ret_ok      = result_valid && (outstanding != '0);
  assign ret_drop    = result_valid && (outstanding == '0);
  assign credit_free = (outstanding - CREDIT_W'(ret_ok)) < CREDIT_W'(MAX_INFLIGHT);

  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);

  // State register
  always_ff @(posedge clk) begin
    if (rst_gen) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and issue decision; the raster sits at (0,0) on entry to LOAD, so the
  // first pixel goes out during LOAD while the shadows load beside it
  always_comb begin
    state_next   = state;
    issue        = 1'b0;
    raster_clear = 1'b0;
    case (state)
      IDLE: begin
        raster_clear = 1'b1;
        if (start) begin
          state_next = LOAD;
        end
      end
      LOAD, ISSUE: begin
        issue = credit_free;
        if (issue && last_pixel) begin
          state_next = DRAIN;
        end else if (state == LOAD) begin
          state_next = ISSUE;
        end
      end
      DRAIN: begin
        if (outstanding == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        raster_clear = 1'b1;
        state_next   = continuous ? LOAD : IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign outstanding_next = outstanding + CREDIT_W'(issue) - CREDIT_W'(ret_ok);

  // Credit counter and sticky underflow flag
  always_ff @(posedge clk) begin
    if (rst_gen) begin
      outstanding   <= '0;
      err_underflow <= 1'b0;
    end else begin
      outstanding <= outstanding_next;
      if (ret_drop) begin
        err_underflow <= 1'b1;
      end
    end
  end

  // Register the issued pixel; coordinates read as zero between pulses
  always_ff @(posedge clk) begin
    if (rst_gen) begin
      pix_valid <= 1'b0;
      screen_x  <= '0;
      screen_y  <= '0;
    end else begin
      pix_valid <= issue;
      screen_x  <= issue ? (FP_W'(x) << FRAC) : '0;
      screen_y  <= issue ? (FP_W'(y) << FRAC) : '0;
    end
  end

  // Completed-frame counter, wrapping naturally at 16 bits
  always_ff @(posedge clk) begin
    if (rst_gen) begin
      frame_count <= '0;
    end else if (state == DONE) begin
      frame_count <= frame_count + 16'd1;
    end
  end

  // Pending parameters follow every update pulse regardless of state
  always_ff @(posedge clk) begin
    if (rst_gen) begin
      pend_camera_forward <= '0;
      pend_camera_right   <= '0;
      pend_ray_origin     <= '0;
      pend_light_pos      <= '0;
      pend_sdf_sel        <= 1'b0;
    end else if (param_update) begin
      pend_camera_forward <= camera_forward_in;
      pend_camera_right   <= camera_right_in;
      pend_ray_origin     <= ray_origin_in;
      pend_light_pos      <= light_pos_in;
      pend_sdf_sel        <= sdf_sel_in;
    end
  end

  // Shadows change only in LOAD; an update landing in LOAD bypasses pending into this frame
  always_ff @(posedge clk) begin
    if (rst_gen) begin
      camera_forward <= '0;
      camera_right   <= '0;
      ray_origin     <= '0;
      light_pos      <= '0;
      sdf_sel        <= 1'b0;
    end else if (state == LOAD) begin
      camera_forward <= param_update ? camera_forward_in : pend_camera_forward;
      camera_right   <= param_update ? camera_right_in   : pend_camera_right;
      ray_origin     <= param_update ? ray_origin_in     : pend_ray_origin;
      light_pos      <= param_update ? light_pos_in      : pend_light_pos;
      sdf_sel        <= param_update ? sdf_sel_in        : pend_sdf_sel;
    end
  end

endmodule

// File: tb/tb_pixel_scan_ctrl.sv
// tb/tb_pixel_scan_ctrl.sv - scoreboard bench for pixel_scan_ctrl on a 4x3 frame
module tb_pixel_scan_ctrl;
  import pixel_scan_ctrl_pkg::*;

  localparam int H = 4;
  localparam int V = 3;

  typedef struct packed {
    logic [31:0] sx;
    logic [31:0] sy;
    logic [95:0] ro;
  } exp_t;

  logic [31:0] coord_tab [0:3] = '{32'h0000_0000, 32'h0020_0000, 32'h0040_0000, 32'h0060_0000};
  logic [95:0] half_ro = {32'h0010_0000, 32'h0000_0000, 32'h0000_0000};

  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_gen = 1'b1;

  logic        a_start = 0, a_cont = 0, a_pu = 0, a_resp_rv = 0, a_force = 0;
  logic [95:0] a_ro_in = '0;
  logic        a_pv, a_sdf, a_busy, a_done, a_err;
  logic [31:0] a_sx, a_sy;
  logic [95:0] a_cf, a_cr, a_ro, a_lp;
  logic [15:0] a_fc;

  logic        b_start = 0, b_resp_rv = 0;
  logic        b_pv, b_sdf, b_busy, b_done, b_err;
  logic [31:0] b_sx, b_sy;
  logic [95:0] b_cf, b_cr, b_ro, b_lp;
  logic [15:0] b_fc;

  pixel_scan_ctrl #(.H_RES(H), .V_RES(V), .MAX_INFLIGHT(1), .FRAC(21)) dut_a (
    .clk(clk), .rst_gen(rst_gen), .start(a_start), .continuous(a_cont), .param_update(a_pu),
    .camera_forward_in('0), .camera_right_in('0), .ray_origin_in(a_ro_in), .light_pos_in('0),
    .sdf_sel_in(1'b0), .result_valid(a_resp_rv | a_force), .pix_valid(a_pv),
    .screen_x(a_sx), .screen_y(a_sy), .camera_forward(a_cf), .camera_right(a_cr),
    .ray_origin(a_ro), .light_pos(a_lp), .sdf_sel(a_sdf), .busy(a_busy),
    .frame_done(a_done), .frame_count(a_fc), .err_underflow(a_err)
  );

  pixel_scan_ctrl #(.H_RES(H), .V_RES(V), .MAX_INFLIGHT(4), .FRAC(21)) dut_b (
    .clk(clk), .rst_gen(rst_gen), .start(b_start), .continuous(1'b0), .param_update(1'b0),
    .camera_forward_in('0), .camera_right_in('0), .ray_origin_in('0), .light_pos_in('0),
    .sdf_sel_in(1'b0), .result_valid(b_resp_rv), .pix_valid(b_pv),
    .screen_x(b_sx), .screen_y(b_sy), .camera_forward(b_cf), .camera_right(b_cr),
    .ray_origin(b_ro), .light_pos(b_lp), .sdf_sel(b_sdf), .busy(b_busy),
    .frame_done(b_done), .frame_count(b_fc), .err_underflow(b_err)
  );

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=missing_or_unexpected required=expected_event", name);
  endtask

  // Scoreboards and responders
  exp_t a_exp[$];
  exp_t b_exp[$];
  int   a_due[$];
  int   b_due[$];
  int   a_pv_cyc[$];
  int   b_pv_cyc[$];
  int   a_lat = 5;
  int   b_lat = 10;
  int   a_pv_n = 0;
  int   b_pv_n = 0;
  int   b_ret_n = 0;
  int   b_max_out = 0;
  int   a_exp_fc = 0;

  task automatic push_frame(input bit to_b, input logic [95:0] ro);
    exp_t e;
    for (int yy = 0; yy < V; yy++) begin
      for (int xx = 0; xx < H; xx++) begin
        e.sx = coord_tab[xx];
        e.sy = coord_tab[yy];
        e.ro = ro;
        if (to_b) b_exp.push_back(e);
        else a_exp.push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin
    a_resp_rv = 1'b0;
    if (rst_gen) begin
      a_due.delete();
    end else begin
      if (a_due.size() > 0 && a_due[0] == cyc) begin
        a_resp_rv = 1'b1;
        void'(a_due.pop_front());
      end
      if (a_pv) begin
        if (a_lat == 0) a_resp_rv = 1'b1;
        else a_due.push_back(cyc + a_lat);
      end
    end
  end

  always @(negedge clk) begin
    b_resp_rv = 1'b0;
    if (rst_gen) begin
      b_due.delete();
    end else begin
      if (b_due.size() > 0 && b_due[0] == cyc) begin
        b_resp_rv = 1'b1;
        b_ret_n++;
        void'(b_due.pop_front());
      end
      if (b_pv) b_due.push_back(cyc + b_lat);
    end
    if (int'(dut_b.outstanding) > b_max_out) b_max_out = int'(dut_b.outstanding);
  end

  always @(negedge clk) begin
    exp_t e;
    if (a_pv) begin
      a_pv_n++;
      a_pv_cyc.push_back(cyc);
      if (a_exp.size() == 0) begin
        fail("a_unexpected_pixel");
      end else begin
        e = a_exp.pop_front();
        chk("a_screen_x", a_sx, e.sx);
        chk("a_screen_y", a_sy, e.sy);
        chk("a_ray_origin", a_ro, e.ro);
      end
    end
    if (a_done) begin
      chk("a_frame_count_at_done", a_fc, a_exp_fc);
      a_exp_fc++;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b_pv) begin
      b_pv_n++;
      b_pv_cyc.push_back(cyc);
      if (b_exp.size() == 0) begin
        fail("b_unexpected_pixel");
      end else begin
        e = b_exp.pop_front();
        chk("b_screen_x", b_sx, e.sx);
        chk("b_screen_y", b_sy, e.sy);
      end
    end
  end

  task automatic start_a();
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
  endtask

  task automatic wait_a_done(input string name);
    int n = 0;
    while (!a_done && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!a_done) fail(name);
  endtask

  task automatic wait_a_pix(input int target, input string name);
    int n = 0;
    while (a_pv_n < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (a_pv_n < target) fail(name);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("a_reset_scalars", {a_pv, a_busy, a_done, a_err, a_sdf, a_fc, a_sx, a_sy}, '0);
    chk("a_reset_vectors", a_cf | a_cr | a_ro | a_lp, '0);
    chk("b_reset_scalars", {b_pv, b_busy, b_done, b_err, b_fc}, '0);
    rst_gen = 1'b0;
    @(negedge clk);

    // One frame, single credit, latency 5
    a_pv_cyc.delete();
    a_pv_n = 0;
    push_frame(1'b0, '0);
    start_a();
    chk("a_busy_c1", a_busy, 1'b1);
    chk("a_pix_valid_c1", a_pv, 1'b0);
    @(negedge clk);
    chk("a_pix_valid_c2", a_pv, 1'b1);
    wait_a_done("a_frame1_done_timeout");
    chk("a_frame1_pixels", a_pv_n, 12);
    chk("a_frame1_queue_empty", a_exp.size(), 0);
    if (a_pv_cyc.size() == 12) chk("a_frame1_span", a_pv_cyc[11] - a_pv_cyc[0], 66);
    else fail("a_frame1_span");
    @(negedge clk);
    chk("a_done_one_cycle", a_done, 1'b0);
    chk("a_busy_after_frame1", a_busy, 1'b0);
    chk("a_frame_count_1", a_fc, 16'd1);

    // Zero-latency return coinciding with an issue keeps one credit in use
    a_lat = 0;
    a_pv_cyc.delete();
    a_pv_n = 0;
    push_frame(1'b0, '0);
    start_a();
    wait_a_done("a_l0_done_timeout");
    if (a_pv_cyc.size() == 12) chk("a_l0_back_to_back", a_pv_cyc[11] - a_pv_cyc[0], 11);
    else fail("a_l0_back_to_back");
    chk("a_l0_no_underflow", a_err, 1'b0);
    @(negedge clk);
    chk("a_frame_count_2", a_fc, 16'd2);

    // Stray return while idle
    a_force = 1'b1;
    @(negedge clk);
    a_force = 1'b0;
    chk("a_err_underflow_set", a_err, 1'b1);
    chk("a_outstanding_stays_0", dut_a.outstanding, 4'd0);

    // Parameter update mid-frame appears only from the next frame
    a_lat = 5;
    a_pv_n = 0;
    push_frame(1'b0, '0);
    push_frame(1'b0, half_ro);
    a_cont = 1'b1;
    start_a();
    wait_a_pix(5, "a_param_pix_timeout");
    a_pu = 1'b1;
    a_ro_in = half_ro;
    @(negedge clk);
    a_pu = 1'b0;
    chk("a_shadow_held", a_ro, '0);
    wait_a_done("a_cont_f1_timeout");
    @(negedge clk);
    a_cont = 1'b0;
    chk("a_cont_reload_busy", a_busy, 1'b1);
    wait_a_done("a_cont_f2_timeout");
    @(negedge clk);
    chk("a_cont_pixels", a_pv_n, 24);
    chk("a_cont_stopped", a_busy, 1'b0);
    chk("a_frame_count_4", a_fc, 16'd4);
    chk("a_shadow_new", a_ro, half_ro);

    // Reset in the middle of a frame
    a_pv_n = 0;
    push_frame(1'b0, half_ro);
    start_a();
    wait_a_pix(5, "a_rst_pix_timeout");
    rst_gen = 1'b1;
    @(negedge clk);
    chk("a_rst_busy", a_busy, 1'b0);
    chk("a_rst_pix_valid", a_pv, 1'b0);
    chk("a_rst_frame_count", a_fc, 16'd0);
    chk("a_rst_err_cleared", a_err, 1'b0);
    chk("a_rst_shadow", a_ro, '0);
    repeat (2) @(negedge clk);
    rst_gen = 1'b0;
    a_exp.delete();
    a_exp_fc = 0;
    a_pv_n = 0;
    push_frame(1'b0, '0);
    start_a();
    wait_a_done("a_restart_timeout");
    @(negedge clk);
    chk("a_restart_pixels", a_pv_n, 12);
    chk("a_restart_frame_count", a_fc, 16'd1);

    // Four credits, latency 10
    b_pv_cyc.delete();
    push_frame(1'b1, '0);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    n = 0;
    while (!b_done && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!b_done) fail("b_done_timeout");
    chk("b_retirements_before_done", b_ret_n, 12);
    chk("b_pixels", b_pv_n, 12);
    chk("b_max_outstanding", b_max_out, 4);
    if (b_pv_cyc.size() == 12) begin
      chk("b_first4_back_to_back", b_pv_cyc[3] - b_pv_cyc[0], 3);
      chk("b_fifth_after_credit", b_pv_cyc[4] - b_pv_cyc[0], 11);
    end else begin
      fail("b_pixel_timing");
    end
    @(negedge clk);
    chk("b_frame_count_1", b_fc, 16'd1);
    chk("b_busy_after", b_busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
